// File: rtl/mem_responder.sv
// Single-port memory responder: captures one request, answers LATENCY+1 cycles later.
// Optional build macro MEMRESP_BOUNDS_CHECK_EN adds out-of-range detection and a fault output.
module mem_responder #(
  parameter int unsigned DEPTH_LOG2 = 12,
  parameter int unsigned LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        request_enable,
  input  logic        mode,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic        response_enable,
  output logic [31:0] data,
  output logic        busy,
`ifdef MEMRESP_BOUNDS_CHECK_EN
  output logic        fault,
`endif
  output logic        overrun
);

  localparam int unsigned DEPTH  = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W  = 4;
  localparam logic        MEMREQ_WRITE = 1'b1;  // read is the complementary value

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic                    resp_q, resp_d;
  logic                    busy_q, busy_d;
  logic                    ovr_q, ovr_d;
  logic                    fault_q, fault_d;
  logic [31:0]             data_q, data_d;

  logic                    mode_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [31:0]             wdata_q;
  logic [3:0]              wstrb_q;
  logic                    oob_q;
  logic                    oob_c;
  logic                    unused_c;

  logic [31:0]             mem [DEPTH];

`ifdef MEMRESP_BOUNDS_CHECK_EN
  assign oob_c    = (addr[31:DEPTH_LOG2+2] != '0);
  assign unused_c = ^addr[1:0];
`else
  // Upper address bits wrap: only the word index is decoded.
  assign oob_c    = 1'b0;
  assign unused_c = ^{addr[31:DEPTH_LOG2+2], addr[1:0]};
`endif

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    ovr_d   = ovr_q;
    case (state_q)
      IDLE: begin
        if (request_enable) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          data_d  = oob_q ? 32'h0 : mem[idx_q];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (request_enable && (state_q != IDLE)) ovr_d = 1'b1;
    resp_d  = (state_d == RESP);
    busy_d  = (state_d != IDLE);
    fault_d = (state_d == RESP) && oob_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      resp_q  <= 1'b0;
      busy_q  <= 1'b0;
      ovr_q   <= 1'b0;
      fault_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      resp_q  <= resp_d;
      busy_q  <= busy_d;
      ovr_q   <= ovr_d;
      fault_q <= fault_d;
      data_q  <= data_d;
    end
  end

  // Request payload is only loaded on acceptance; later bus values are ignored.
  always_ff @(posedge clk) begin
    if (state_q == IDLE && request_enable) begin
      mode_q  <= mode;
      idx_q   <= addr[DEPTH_LOG2+1:2];
      wdata_q <= wdata;
      wstrb_q <= wstrb;
      oob_q   <= oob_c;
    end
  end

  // Array commits at the end of RESP, after data has captured the pre-write word.
  always_ff @(posedge clk) begin
    if (rstn && state_q == RESP && mode_q == MEMREQ_WRITE && !oob_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign response_enable = resp_q;
  assign data            = data_q;
  assign busy            = busy_q;
  assign overrun         = ovr_q;
`ifdef MEMRESP_BOUNDS_CHECK_EN
  assign fault           = fault_q;
`else
  logic unused_fault_c;
  assign unused_fault_c = fault_q ^ unused_c;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: LATENCY=2 instance for function, LATENCY=1 for back-to-back.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req, req1;
  logic        mode;
  logic [31:0] addr, wdata;
  logic [3:0]  wstrb;
  logic        resp, busy, ovr;
  logic [31:0] data;
  logic        resp1, busy1, ovr1;
  logic [31:0] data1;
`ifdef MEMRESP_BOUNDS_CHECK_EN
  logic        fault, fault1;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  mem_responder #(.DEPTH_LOG2(12), .LATENCY(2)) dut (
    .clk(clk), .rstn(rstn), .request_enable(req), .mode(mode), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .response_enable(resp), .data(data), .busy(busy),
`ifdef MEMRESP_BOUNDS_CHECK_EN
    .fault(fault),
`endif
    .overrun(ovr)
  );

  mem_responder #(.DEPTH_LOG2(4), .LATENCY(1)) dut1 (
    .clk(clk), .rstn(rstn), .request_enable(req1), .mode(mode), .addr(addr),
    .wdata(wdata), .wstrb(wstrb), .response_enable(resp1), .data(data1), .busy(busy1),
`ifdef MEMRESP_BOUNDS_CHECK_EN
    .fault(fault1),
`endif
    .overrun(ovr1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One request on the LATENCY=2 instance; response expected exactly 3 edges after capture.
  task automatic do_req(input string tag, input logic m, input logic [31:0] a,
                        input logic [31:0] w, input logic [3:0] s,
                        input logic chk_data, input logic [31:0] exp, input logic exp_fault);
    mode = m; addr = a; wdata = w; wstrb = s; req = 1'b1;
    tick();
    req = 1'b0; mode = ~m; addr = $urandom; wdata = $urandom; wstrb = 4'($urandom);
    chk({tag, ".busy"}, 32'(busy), 32'd1);
    chk({tag, ".resp_n1"}, 32'(resp), 32'd0);
    tick();
    chk({tag, ".resp_n2"}, 32'(resp), 32'd0);
    tick();
    chk({tag, ".resp_n3"}, 32'(resp), 32'd1);
    if (chk_data) chk({tag, ".data"}, data, exp);
`ifdef MEMRESP_BOUNDS_CHECK_EN
    chk({tag, ".fault"}, 32'(fault), 32'(exp_fault));
`else
    if (exp_fault) chk({tag, ".fault_unexpected"}, 32'd1, 32'd0);
`endif
    tick();
    chk({tag, ".resp_off"}, 32'(resp), 32'd0);
    chk({tag, ".idle"}, 32'(busy), 32'd0);
    if (chk_data) chk({tag, ".data_hold"}, data, exp);
  endtask

  initial begin
    rstn = 1'b0; req = 1'b0; req1 = 1'b0; mode = 1'b0;
    addr = '0; wdata = '0; wstrb = '0;
    tick(); tick();
    rstn = 1'b1;
    chk("rst.resp", 32'(resp), 32'd0);
    chk("rst.data", data, 32'd0);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.ovr", 32'(ovr), 32'd0);
    chk("rst1.resp", 32'(resp1), 32'd0);
    chk("rst1.data", data1, 32'd0);

    // Full-word write then readback; second write returns the prior word.
    do_req("w10a", 1'b1, 32'h10, 32'h0123_4567, 4'hF, 1'b0, 32'h0, 1'b0);
    do_req("w10b", 1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 32'h0123_4567, 1'b0);
    do_req("r10",  1'b0, 32'h13, 32'h0, 4'h0, 1'b1, 32'hDEAD_BEEF, 1'b0);

    // Byte-lane merge and empty strobe.
    do_req("w20a", 1'b1, 32'h20, 32'h1122_3344, 4'hF, 1'b0, 32'h0, 1'b0);
    do_req("w20b", 1'b1, 32'h20, 32'h00AB_0000, 4'b0100, 1'b1, 32'h1122_3344, 1'b0);
    do_req("r20a", 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h11AB_3344, 1'b0);
    do_req("w20c", 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, 1'b1, 32'h11AB_3344, 1'b0);
    do_req("r20b", 1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 32'h11AB_3344, 1'b0);

    // Address beyond the array.
    do_req("w00", 1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, 1'b0, 32'h0, 1'b0);
`ifdef MEMRESP_BOUNDS_CHECK_EN
    do_req("r4000", 1'b0, 32'h0000_4000, 32'h0, 4'h0, 1'b1, 32'h0, 1'b1);
`else
    do_req("r4000", 1'b0, 32'h0000_4000, 32'h0, 4'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
`endif

    // Overlapping request is dropped and flags overrun.
    do_req("w40a", 1'b1, 32'h40, 32'hAAAA_5555, 4'hF, 1'b0, 32'h0, 1'b0);
    mode = 1'b1; addr = 32'h40; wdata = 32'h5A5A_0001; wstrb = 4'hF; req = 1'b1;
    tick();
    chk("ovr.n0", 32'(ovr), 32'd0);
    wdata = 32'h1234_5678;
    tick();
    req = 1'b0;
    chk("ovr.set", 32'(ovr), 32'd1);
    chk("ovr.resp_n1", 32'(resp), 32'd0);
    tick();
    chk("ovr.resp_n2", 32'(resp), 32'd1);
    chk("ovr.data", data, 32'hAAAA_5555);
    tick();
    chk("ovr.resp_off", 32'(resp), 32'd0);
    tick();
    chk("ovr.no_second", 32'(resp), 32'd0);
    chk("ovr.sticky", 32'(ovr), 32'd1);
    do_req("r40", 1'b0, 32'h40, 32'h0, 4'h0, 1'b1, 32'h5A5A_0001, 1'b0);

    // Reset during WAIT discards the write.
    do_req("w30a", 1'b1, 32'h30, 32'h3030_3030, 4'hF, 1'b0, 32'h0, 1'b0);
    mode = 1'b1; addr = 32'h30; wdata = 32'hBADB_AD00; wstrb = 4'hF; req = 1'b1;
    tick();
    req = 1'b0;
    chk("rstw.busy", 32'(busy), 32'd1);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    chk("rstw.busy0", 32'(busy), 32'd0);
    chk("rstw.ovr0", 32'(ovr), 32'd0);
    chk("rstw.data0", data, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("rstw.no_resp", 32'(resp), 32'd0);
      tick();
    end
    do_req("r30", 1'b0, 32'h30, 32'h0, 4'h0, 1'b1, 32'h3030_3030, 1'b0);

    // LATENCY=1: ten writes then ten reads, each issued the cycle after the prior response.
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 10; i++) begin
        mode = (p == 0); addr = 32'(i * 4); wdata = 32'hA500_0000 | 32'(i); wstrb = 4'hF;
        req1 = 1'b1;
        tick();
        req1 = 1'b0; addr = $urandom; wdata = $urandom;
        chk("b2b.resp_n1", 32'(resp1), 32'd0);
        tick();
        chk("b2b.resp_n2", 32'(resp1), 32'd1);
        if (p == 1) chk("b2b.data", data1, 32'hA500_0000 | 32'(i));
        tick();
        chk("b2b.resp_off", 32'(resp1), 32'd0);
      end
    end
    chk("b2b.ovr", 32'(ovr1), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
